// File: rtl/apb_cat_sequencer.sv
// APB slave front-end and inference sequencer for the cat-recognition neuron.
// Decodes CTRL/BIAS/STATUS registers and the pixel window, then sweeps the
// pixel/weight memories, requests the calculator decision and raises irq.
module apb_cat_sequencer #(
    parameter int AMBA_WORD       = 24,
    parameter int AMBA_ADDR_DEPTH = 12,
    parameter int PIX_BASE        = 'h100,
    parameter int PIXEL_COUNT     = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_ADDR_DEPTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       pix_we,
    output logic [AMBA_ADDR_DEPTH-1:0] pix_addr,
    output logic [AMBA_WORD-1:0]       pix_wdata,
    output logic                       mem_rd_en,
    output logic [AMBA_ADDR_DEPTH-1:0] mem_rd_addr,
    output logic                       calc_en,
    output logic [AMBA_WORD-1:0]       calc_bias,
    output logic                       calc_get_result,
    input  logic                       calc_result,
    output logic                       irq
);

    localparam int A = AMBA_ADDR_DEPTH;
    localparam int W = AMBA_WORD;

    localparam logic [A-1:0] ADDR_CTRL   = A'(0);
    localparam logic [A-1:0] ADDR_BIAS   = A'(1);
    localparam logic [A-1:0] ADDR_STATUS = A'(2);
    localparam logic [A-1:0] PIX_LO      = A'(PIX_BASE);
    // One bit wider so the window may end exactly at the top of the address space.
    localparam logic [A:0]   PIX_HI      = (A+1)'(PIX_BASE + PIXEL_COUNT);
    localparam logic [A-1:0] CNT_LAST    = A'(PIXEL_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_RESULT,
        S_CAPTURE
    } state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   bias_q, bias_d;
    logic [W-1:0]   cbias_q, cbias_d;
    logic           done_q, done_d;
    logic           result_q, result_d;
    logic           calc_en_q;
    logic           drop_q;

    logic           access;
    logic           pix_hit;
    logic           busy;
    logic           pix_stall;
    logic           wr_acc;
    logic           rd_acc;
    logic           start;

    // APB decode: a pixel write is held off while the sequencer owns the memories.
    // drop_q swallows a pixel write that was stalled when reset hit, letting the
    // master finish the transfer without it reaching the memory.
    assign access    = PSEL & PENABLE;
    assign pix_hit   = (PADDR >= PIX_LO) && ({1'b0, PADDR} < PIX_HI);
    assign busy      = (state_q != S_IDLE);
    assign pix_stall = access & PWRITE & pix_hit & busy & ~drop_q;
    assign PREADY    = ~pix_stall;
    assign wr_acc    = access & PWRITE & ~pix_stall;
    assign rd_acc    = access & ~PWRITE;
    assign start     = wr_acc && (PADDR == ADDR_CTRL) && PWDATA[0] && (state_q == S_IDLE);

    assign pix_we    = access & PWRITE & pix_hit & ~busy & ~drop_q;
    assign pix_addr  = pix_we ? (PADDR - PIX_LO) : '0;
    assign pix_wdata = pix_we ? PWDATA : '0;

    assign calc_en   = calc_en_q;
    assign calc_bias = cbias_q;

    // Read mux: zero-wait, driven only during a read ACCESS cycle.
    always_comb begin
        PRDATA = '0;
        if (rd_acc) begin
            case (PADDR)
                ADDR_BIAS:   PRDATA = bias_q;
                ADDR_STATUS: PRDATA = W'({result_q, done_q, busy});
                default:     PRDATA = '0;
            endcase
        end
    end

    // Next-state, register updates and sequencer strobes.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bias_d          = bias_q;
        cbias_d         = cbias_q;
        done_d          = done_q;
        result_d        = result_q;
        mem_rd_en       = 1'b0;
        mem_rd_addr     = '0;
        calc_get_result = 1'b0;
        irq             = 1'b0;

        if (wr_acc && (PADDR == ADDR_BIAS)) begin
            bias_d = PWDATA;
        end
        // Read-to-clear comes first so a capture in the same cycle still sets done.
        if (rd_acc && (PADDR == ADDR_STATUS)) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    cbias_d = bias_q;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = cnt_q;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + A'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_RESULT;
            end
            S_RESULT: begin
                calc_get_result = 1'b1;
                state_d         = S_CAPTURE;
            end
            S_CAPTURE: begin
                irq      = 1'b1;
                result_d = calc_result;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, register file, bias snapshot and the one-cycle read-latency delay of calc_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bias_q    <= '0;
            cbias_q   <= '0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            calc_en_q <= 1'b0;
            drop_q    <= pix_stall;
        end else begin
            cnt_q     <= cnt_d;
            bias_q    <= bias_d;
            cbias_q   <= cbias_d;
            done_q    <= done_d;
            result_q  <= result_d;
            calc_en_q <= mem_rd_en;
            drop_q    <= drop_q & access;
        end
    end

endmodule

// File: tb/tb_apb_cat_sequencer.sv
// Directed/randomized bench for apb_cat_sequencer with a transaction-level model.
module tb_apb_cat_sequencer;

    localparam int W    = 24;
    localparam int A    = 12;
    localparam int BASE = 'h100;
    localparam int P    = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         PSEL, PENABLE, PWRITE;
    logic [A-1:0] PADDR;
    logic [W-1:0] PWDATA;
    logic [W-1:0] PRDATA;
    logic         PREADY;
    logic         pix_we;
    logic [A-1:0] pix_addr;
    logic [W-1:0] pix_wdata;
    logic         mem_rd_en;
    logic [A-1:0] mem_rd_addr;
    logic         calc_en;
    logic [W-1:0] calc_bias;
    logic         calc_get_result;
    logic         calc_result;
    logic         irq;

    int checks   = 0;
    int failures = 0;

    // Model of the programmer-visible state.
    logic [W-1:0] bias_m   = '0;
    logic         done_m   = 1'b0;
    logic         result_m = 1'b0;

    apb_cat_sequencer #(
        .AMBA_WORD      (W),
        .AMBA_ADDR_DEPTH(A),
        .PIX_BASE       (BASE),
        .PIXEL_COUNT    (P)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PADDR          (PADDR),
        .PWDATA         (PWDATA),
        .PRDATA         (PRDATA),
        .PREADY         (PREADY),
        .pix_we         (pix_we),
        .pix_addr       (pix_addr),
        .pix_wdata      (pix_wdata),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .calc_en        (calc_en),
        .calc_bias      (calc_bias),
        .calc_get_result(calc_get_result),
        .calc_result    (calc_result),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic apb_idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
    endtask

    function automatic logic [31:0] status_m(input logic busy);
        return {29'd0, result_m, done_m, busy};
    endfunction

    task automatic apb_write(input logic [A-1:0] a, input logic [W-1:0] d);
        logic in_pix;
        in_pix = (int'(a) >= BASE) && (int'(a) < BASE + P);
        step();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        settle();
        chk("setup_pix_we", 32'(pix_we), 32'd0);
        step();
        PENABLE = 1'b1;
        settle();
        chk("wr_pready", 32'(PREADY), 32'd1);
        chk("wr_pix_we", 32'(pix_we), 32'(in_pix));
        chk("wr_pix_addr", 32'(pix_addr), in_pix ? 32'(int'(a) - BASE) : 32'd0);
        chk("wr_pix_wdata", 32'(pix_wdata), in_pix ? 32'(d) : 32'd0);
        step();
        apb_idle();
        settle();
        chk("post_pix_we", 32'(pix_we), 32'd0);
        if (a == A'(1)) bias_m = d;
    endtask

    task automatic apb_read(input logic [A-1:0] a, input logic [31:0] exp, input string tag);
        step();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        settle();
        chk("setup_prdata", 32'(PRDATA), 32'd0);
        step();
        PENABLE = 1'b1;
        settle();
        chk(tag, 32'(PRDATA), exp);
        step();
        apb_idle();
        settle();
        if (a == A'(2)) done_m = 1'b0;
    endtask

    // mode 0: STATUS read in CAPTURE; 1: START/BIAS/pixel write while busy;
    // 2: reset at t+4 with a stalled pixel write; 3: START in CAPTURE.
    task automatic do_run(input int mode, input logic res);
        logic [W-1:0] snap, newb, pd;
        logic [A-1:0] pa;
        logic         live;
        logic         exp_rd, exp_cen, exp_get, exp_irq, exp_rdy, exp_pwe;
        logic [31:0]  exp_addr;
        snap = bias_m;
        newb = W'($urandom);
        pd   = W'($urandom);
        pa   = A'(BASE + int'($urandom_range(0, P - 1)));
        step();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A'(0); PWDATA = W'(1);
        step();
        PENABLE = 1'b1;
        settle();
        chk("start_pready", 32'(PREADY), 32'd1);
        chk("start_rd_en", 32'(mem_rd_en), 32'd0);
        for (int k = 1; k <= P + 5; k++) begin
            step();
            apb_idle();
            rst = 1'b0;
            calc_result = (k == P + 3) ? res : ~res;
            case (mode)
                0: begin
                    if (k == P + 2 || k == P + 3) begin
                        PSEL = 1'b1; PADDR = A'(2); PENABLE = (k == P + 3);
                    end
                end
                1: begin
                    if (k == 2 || k == 3) begin
                        PSEL = 1'b1; PWRITE = 1'b1; PADDR = A'(0); PWDATA = W'(1); PENABLE = (k == 3);
                    end else if (k == 4 || k == 5) begin
                        PSEL = 1'b1; PWRITE = 1'b1; PADDR = A'(1); PWDATA = newb; PENABLE = (k == 5);
                    end else if (k >= 6 && k <= P + 4) begin
                        PSEL = 1'b1; PWRITE = 1'b1; PADDR = pa; PWDATA = pd; PENABLE = (k >= 7);
                    end
                end
                2: begin
                    if (k >= 2 && k <= 5) begin
                        PSEL = 1'b1; PWRITE = 1'b1; PADDR = pa; PWDATA = pd; PENABLE = (k >= 3);
                    end
                    rst = (k == 4);
                end
                3: begin
                    if (k == P + 2 || k == P + 3) begin
                        PSEL = 1'b1; PWRITE = 1'b1; PADDR = A'(0); PWDATA = W'(1); PENABLE = (k == P + 3);
                    end
                end
                default: ;
            endcase
            settle();
            live     = !(mode == 2 && k >= 5);
            exp_rd   = live && k >= 1 && k <= P;
            exp_addr = exp_rd ? 32'(k - 1) : 32'd0;
            exp_cen  = live && k >= 2 && k <= P + 1;
            exp_get  = live && k == P + 2;
            exp_irq  = live && k == P + 3;
            exp_rdy  = 1'b1;
            if (mode == 1) exp_rdy = !(k >= 7 && k <= P + 3);
            if (mode == 2) exp_rdy = !(k == 3 || k == 4);
            exp_pwe  = (mode == 1) && (k == P + 4);
            chk($sformatf("mem_rd_en_k%0d", k), 32'(mem_rd_en), 32'(exp_rd));
            chk($sformatf("mem_rd_addr_k%0d", k), 32'(mem_rd_addr), exp_addr);
            chk($sformatf("calc_en_k%0d", k), 32'(calc_en), 32'(exp_cen));
            chk($sformatf("get_result_k%0d", k), 32'(calc_get_result), 32'(exp_get));
            chk($sformatf("irq_k%0d", k), 32'(irq), 32'(exp_irq));
            chk($sformatf("pready_k%0d", k), 32'(PREADY), 32'(exp_rdy));
            chk($sformatf("pix_we_k%0d", k), 32'(pix_we), 32'(exp_pwe));
            chk($sformatf("calc_bias_k%0d", k), 32'(calc_bias), live ? 32'(snap) : 32'd0);
            if (exp_pwe) begin
                chk("stalled_pix_addr", 32'(pix_addr), 32'(int'(pa) - BASE));
                chk("stalled_pix_wdata", 32'(pix_wdata), 32'(pd));
            end
            if (mode == 0 && k == P + 3)
                chk("status_in_capture", 32'(PRDATA), {29'd0, result_m, 1'b0, 1'b1});
            else
                chk($sformatf("prdata_k%0d", k), 32'(PRDATA), 32'd0);
        end
        rst = 1'b0;
        calc_result = 1'b0;
        if (mode == 2) begin
            bias_m = '0; done_m = 1'b0; result_m = 1'b0;
        end else begin
            if (mode == 1) bias_m = newb;
            done_m = 1'b1;
            result_m = res;
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic [A-1:0] a;
        rst = 1'b1;
        calc_result = 1'b0;
        apb_idle();
        repeat (2) step();
        settle();
        chk("rst_prdata", 32'(PRDATA), 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd1);
        chk("rst_pix_we", 32'(pix_we), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_calc_en", 32'(calc_en), 32'd0);
        chk("rst_get_result", 32'(calc_get_result), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_calc_bias", 32'(calc_bias), 32'd0);
        rst = 1'b0;
        apb_read(A'(2), 32'd0, "rst_status");
        apb_read(A'(1), 32'd0, "rst_bias");

        // Pixel loads and address boundaries.
        apb_write(A'('h105), W'('h123456));
        for (int i = 0; i < 3; i++) begin
            a = A'(BASE + int'($urandom_range(0, P - 1)));
            d = W'($urandom);
            apb_write(a, d);
        end
        apb_write(A'(BASE + P), W'('hABCDEF));
        apb_write(A'('h0FF), W'('h654321));
        apb_read(A'(BASE + 3), 32'd0, "read_pixel_space");
        apb_read(A'('h0FF), 32'd0, "read_unmapped");
        apb_read(A'(0), 32'd0, "read_ctrl");

        // Reference run with BIAS=0x10 and a positive decision.
        apb_write(A'(1), W'('h000010));
        apb_read(A'(1), 32'h10, "bias_readback");
        do_run(0, 1'b1);
        apb_read(A'(2), status_m(1'b0), "status_done");
        apb_read(A'(2), status_m(1'b0), "status_done_cleared");

        // Busy: START ignored, BIAS updates register only, pixel write stalls.
        do_run(1, 1'($urandom));
        apb_read(A'(1), 32'(bias_m), "bias_written_while_busy");
        apb_read(A'(2), status_m(1'b0), "status_after_busy_run");

        // Reset during RUN, then a clean run with random bias.
        apb_write(A'(1), W'($urandom));
        do_run(2, 1'b1);
        apb_read(A'(2), 32'd0, "status_after_reset");
        apb_read(A'(1), 32'd0, "bias_after_reset");
        apb_write(A'(1), W'($urandom));
        do_run(0, 1'($urandom));
        apb_read(A'(2), status_m(1'b0), "status_after_rerun");

        // START during CAPTURE is ignored.
        do_run(3, 1'($urandom));
        apb_read(A'(2), status_m(1'b0), "status_after_capture_start");
        apb_read(A'(2), status_m(1'b0), "status_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
